// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, CAUSE bit
// positions and the counter-width helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STRETCH   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_LOCK = 2;
  localparam int CAUSE_SW   = 3;

  // Counters only ever hold 0..max-1, so $clog2(max) bits suffice; keep >= 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Request/status bundle between the reset sequencer (slave) and its
// surroundings (master).
interface reset_seq_if #(
  parameter int N_LOCK = 2,
  parameter int N_OUT  = 3
);
  logic              BTN;
  logic [N_LOCK-1:0] LOCKED;
  logic              SW_RST;
  logic              CAUSE_CLR;
  logic [N_OUT-1:0]  RSTn;
  logic              DONE;
  logic [3:0]        CAUSE;

  modport master (
    output BTN, LOCKED, SW_RST, CAUSE_CLR,
    input  RSTn, DONE, CAUSE
  );

  modport slave (
    input  BTN, LOCKED, SW_RST, CAUSE_CLR,
    output RSTn, DONE, CAUSE
  );
endinterface

// File: rtl/reset_seq_debounce.sv
// Pushbutton synchroniser plus glitch filter: the filtered level follows the
// synchronised input only after DEBOUNCE consecutive differing cycles.
module reset_seq_debounce #(
  parameter int DEBOUNCE = 8,
  parameter int CNT_W    = 3
) (
  input  logic CLK,
  input  logic PORESETn,
  input  logic btn_i,
  output logic btn_filt_o
);

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any cycle where input agrees with the filtered level restarts the run.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) filt_d = sync_q[1];
      else                               cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  assign btn_filt_o = filt_q;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: waits for PLL lock and a clean button, stretches, then
// releases RSTn[0..N_OUT-1] in order STAGGER cycles apart; any fault re-asserts all.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_LOCK   = 2,
  parameter int N_OUT    = 3,
  parameter int STRETCH  = 15,
  parameter int STAGGER  = 4,
  parameter int DEBOUNCE = 8
) (
  input  logic        CLK,
  input  logic        PORESETn,
  reset_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(STRETCH, STAGGER, DEBOUNCE);

  logic [N_LOCK-1:0] lock_s1_q, lock_s2_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_OUT-1:0]  rstn_q, rstn_d, rstn_shift;
  logic [3:0]        cause_q, cause_d, cause_set;
  logic              btn_filt, lock_fault, fault, in_seq;

  reset_seq_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_debounce (
    .CLK        (CLK),
    .PORESETn   (PORESETn),
    .btn_i      (bus.BTN),
    .btn_filt_o (btn_filt)
  );

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      lock_s1_q <= '0;
      lock_s2_q <= '0;
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      rstn_q    <= '0;
      cause_q   <= 4'b0001;
    end else begin
      lock_s1_q <= bus.LOCKED;
      lock_s2_q <= lock_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rstn_q    <= rstn_d;
      cause_q   <= cause_d;
    end
  end

  assign lock_fault = ~&lock_s2_q;
  assign fault      = btn_filt | lock_fault | bus.SW_RST;
  assign in_seq     = (state_q == ST_STRETCH) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
  // Releases are a thermometer fill from bit 0, so individual bits never drop.
  assign rstn_shift = N_OUT'({rstn_q, 1'b1});

  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_BTN]  = btn_filt;
    cause_set[CAUSE_LOCK] = lock_fault;
    cause_set[CAUSE_SW]   = bus.SW_RST;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    cause_d = bus.CAUSE_CLR ? 4'b0000 : cause_q;

    if (fault && in_seq) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      rstn_d  = '0;
      cause_d = cause_d | cause_set;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          rstn_d  = '0;
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (!fault) begin
            cnt_d   = '0;
            state_d = ST_STRETCH;
          end
        end
        ST_STRETCH, ST_RELEASE: begin
          if (cnt_q == ((state_q == ST_STRETCH) ? CNT_W'(STRETCH - 1) : CNT_W'(STAGGER - 1))) begin
            cnt_d   = '0;
            rstn_d  = rstn_shift;
            state_d = (&rstn_shift) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: state_d = ST_RUN;
        default: begin
          rstn_d  = '0;
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  assign bus.RSTn  = rstn_q;
  assign bus.DONE  = (state_q == ST_RUN);
  assign bus.CAUSE = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default build plus an N_OUT=1/STRETCH=1 build,
// edge numbers counted from PORESETn release.
module tb_reset_seq;

  logic CLK = 1'b0;
  logic PORESETn;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   ecnt    = 0;

  reset_seq_if #(.N_LOCK(2), .N_OUT(3)) bus ();
  reset_seq_if #(.N_LOCK(2), .N_OUT(1)) bus1 ();

  reset_seq #(.N_LOCK(2), .N_OUT(3), .STRETCH(15), .STAGGER(4), .DEBOUNCE(8)) dut (
    .CLK      (CLK),
    .PORESETn (PORESETn),
    .bus      (bus.slave)
  );

  reset_seq #(.N_LOCK(2), .N_OUT(1), .STRETCH(1), .STAGGER(4), .DEBOUNCE(8)) dut1 (
    .CLK      (CLK),
    .PORESETn (PORESETn),
    .bus      (bus1.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) step();
  endtask

  initial begin
    PORESETn       = 1'b0;
    bus.BTN        = 1'b0;
    bus.LOCKED     = 2'b11;
    bus.SW_RST     = 1'b0;
    bus.CAUSE_CLR  = 1'b0;
    bus1.BTN       = 1'b0;
    bus1.LOCKED    = 2'b11;
    bus1.SW_RST    = 1'b0;
    bus1.CAUSE_CLR = 1'b0;

    #22;
    chk("rst_rstn",  32'(bus.RSTn),  32'h0);
    chk("rst_done",  32'(bus.DONE),  32'h0);
    chk("rst_cause", 32'(bus.CAUSE), 32'h1);
    chk("rst_rstn1", 32'(bus1.RSTn), 32'h0);
    PORESETn = 1'b1;
    ecnt     = 0;

    // Power-up sequence: sync 2 edges, ASSERT->WAIT_LOCK->STRETCH at 3, +15, +4, +4.
    run_to(3);  chk("n1_e3",     32'(bus1.RSTn), 32'h0);
    run_to(4);  chk("n1_e4",     32'(bus1.RSTn), 32'h1);
    run_to(17); chk("pu_e17",    32'(bus.RSTn),  32'h0);
    run_to(18); chk("pu_e18",    32'(bus.RSTn),  32'h1);
    run_to(21); chk("pu_e21",    32'(bus.RSTn),  32'h1);
    run_to(22); chk("pu_e22",    32'(bus.RSTn),  32'h3);
    run_to(25); chk("pu_done25", 32'(bus.DONE),  32'h0);
    run_to(26); chk("pu_e26",    32'(bus.RSTn),  32'h7);
    chk("pu_done26", 32'(bus.DONE),  32'h1);
    chk("pu_cause",  32'(bus.CAUSE), 32'h1);

    // Short button press is filtered out.
    run_to(30); bus.BTN = 1'b1;
    run_to(35); bus.BTN = 1'b0;
    run_to(50); chk("btn_short_rstn", 32'(bus.RSTn), 32'h7);
    chk("btn_short_done", 32'(bus.DONE), 32'h1);

    // One-cycle lock drop: faults on the third edge, DONE back at 57+23.
    run_to(52); bus.LOCKED = 2'b01;
    run_to(53); bus.LOCKED = 2'b11;
    run_to(54); chk("lk_e54_rstn",  32'(bus.RSTn),  32'h7);
    run_to(55); chk("lk_e55_rstn",  32'(bus.RSTn),  32'h0);
    chk("lk_cause", 32'(bus.CAUSE), 32'h5);
    run_to(72); chk("lk_e72_rstn",  32'(bus.RSTn),  32'h1);
    run_to(79); chk("lk_done79",    32'(bus.DONE),  32'h0);
    run_to(80); chk("lk_done80",    32'(bus.DONE),  32'h1);

    // Clear coinciding with a lock fault: the new cause survives.
    run_to(90); bus.LOCKED = 2'b10;
    run_to(92); bus.LOCKED = 2'b11; bus.CAUSE_CLR = 1'b1;
    run_to(93); bus.CAUSE_CLR = 1'b0;
    chk("clr_fault_cause", 32'(bus.CAUSE), 32'h4);
    chk("clr_fault_rstn",  32'(bus.RSTn),  32'h0);
    run_to(118); chk("clr_done118", 32'(bus.DONE), 32'h1);
    run_to(120); bus.CAUSE_CLR = 1'b1;
    run_to(121); bus.CAUSE_CLR = 1'b0;
    chk("clr_alone", 32'(bus.CAUSE), 32'h0);

    // Long press: filtered high at 135, ASSERT at 136, held until filter drops at 155.
    run_to(125); bus.BTN = 1'b1;
    run_to(135); chk("btn_e135", 32'(bus.RSTn), 32'h7);
    run_to(136); chk("btn_e136", 32'(bus.RSTn), 32'h0);
    chk("btn_cause", 32'(bus.CAUSE), 32'h2);
    run_to(145); bus.BTN = 1'b0;
    run_to(170); chk("btn_hold170", 32'(bus.RSTn), 32'h0);
    run_to(171); chk("btn_rel171",  32'(bus.RSTn), 32'h1);

    // Software reset during RELEASE.
    run_to(172); bus.SW_RST = 1'b1;
    run_to(173); bus.SW_RST = 1'b0;
    chk("sw_e173_rstn", 32'(bus.RSTn),  32'h0);
    chk("sw_cause",     32'(bus.CAUSE), 32'hA);
    run_to(190); chk("sw_e190",    32'(bus.RSTn), 32'h1);
    run_to(197); chk("sw_done197", 32'(bus.DONE), 32'h0);
    run_to(198); chk("sw_done198", 32'(bus.DONE), 32'h1);
    chk("sw_e198_rstn", 32'(bus.RSTn), 32'h7);

    // Power-on reset asserted mid-RELEASE, between clock edges.
    bus.CAUSE_CLR = 1'b1;
    run_to(199); bus.CAUSE_CLR = 1'b0;
    bus.LOCKED = 2'b00;
    run_to(200); bus.LOCKED = 2'b11;
    run_to(219); chk("por_pre_rstn", 32'(bus.RSTn), 32'h1);
    #2;
    PORESETn = 1'b0;
    #1;
    chk("por_async_rstn",  32'(bus.RSTn),  32'h0);
    chk("por_async_done",  32'(bus.DONE),  32'h0);
    chk("por_async_cause", 32'(bus.CAUSE), 32'h1);
    #2;
    PORESETn = 1'b1;
    ecnt     = 0;
    run_to(17); chk("por2_e17", 32'(bus.RSTn), 32'h0);
    run_to(18); chk("por2_e18", 32'(bus.RSTn), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
